// File: rtl/fetch_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fetch_sequencer                                               |
// | Brief    : Program counter and byte-serial fetch that assembles 32-bit   |
// |            little-endian instruction words for the Control_Unit.         |
// | Revision : 1.0                                                           |
// +--------------------------------------------------------------------------+
module fetch_sequencer #(
    parameter int MEM_DATA_LENGTH = 8,
    parameter int WORD_SIZE       = 4 * MEM_DATA_LENGTH,
    parameter int MEM_LENGTH      = 64,
    parameter int ADDR_WIDTH      = $clog2(MEM_LENGTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    input  logic [MEM_DATA_LENGTH-1:0] mem_rdata,
    output logic [WORD_SIZE-1:0]       instr,
    output logic                       instr_valid,
    input  logic                       instr_ready,
    output logic [ADDR_WIDTH-1:0]      pc,
    input  logic                       redirect,
    input  logic [ADDR_WIDTH-1:0]      redirect_addr,
    output logic                       busy
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_VALID = 2'd2
    } state_t;

    localparam logic [2:0] C_LAST_BEAT = 3'd4;

    state_t                  r_state_q, w_state_d;
    logic [2:0]              r_beat_q,  w_beat_d;
    logic [ADDR_WIDTH-1:0]   r_pc_q,    w_pc_d;
    logic [WORD_SIZE-1:0]    r_instr_q, w_instr_d;
    logic                    w_unused_redirect_lsbs;

    assign w_unused_redirect_lsbs = ^redirect_addr[1:0];

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state_q <= S_IDLE;
            r_beat_q  <= 3'd0;
            r_pc_q    <= '0;
            r_instr_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_beat_q  <= w_beat_d;
            r_pc_q    <= w_pc_d;
            r_instr_q <= w_instr_d;
        end
    end

    always_comb begin
        w_state_d = r_state_q;
        w_beat_d  = r_beat_q;
        w_pc_d    = r_pc_q;
        w_instr_d = r_instr_q;
        case (r_state_q)
            S_IDLE: begin
                if (start) begin
                    w_state_d = S_FETCH;
                    w_beat_d  = 3'd0;
                    w_pc_d    = '0;
                end
            end
            S_FETCH: begin
                // Byte requested in beat k-1 arrives during beat k.
                for (int k = 0; k < 4; k++) begin
                    if (r_beat_q == 3'(k + 1)) begin
                        w_instr_d[MEM_DATA_LENGTH*k +: MEM_DATA_LENGTH] = mem_rdata;
                    end
                end
                if (r_beat_q == C_LAST_BEAT) begin
                    w_state_d = S_VALID;
                    w_beat_d  = 3'd0;
                end else begin
                    w_beat_d = r_beat_q + 3'd1;
                end
            end
            S_VALID: begin
                if (instr_ready) begin
                    w_pc_d    = r_pc_q + ADDR_WIDTH'(4);
                    w_state_d = S_FETCH;
                    w_beat_d  = 3'd0;
                end
            end
            default: begin
                w_state_d = S_IDLE;
                w_beat_d  = 3'd0;
            end
        endcase

        // Redirect overrides any handshake or capture in progress.
        if (redirect && (r_state_q != S_IDLE)) begin
            w_state_d = S_FETCH;
            w_beat_d  = 3'd0;
            w_pc_d    = {redirect_addr[ADDR_WIDTH-1:2], 2'b00};
            w_instr_d = r_instr_q;
        end
    end

    assign mem_addr    = ((r_state_q == S_FETCH) && (r_beat_q != C_LAST_BEAT))
                         ? (r_pc_q + ADDR_WIDTH'(r_beat_q)) : r_pc_q;
    assign instr       = r_instr_q;
    assign pc          = r_pc_q;
    assign instr_valid = (r_state_q == S_VALID);
    assign busy        = (r_state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
`default_nettype none
// Scoreboard bench for fetch_sequencer: stimulus pushes expected words,
// a negedge monitor compares every presented word and counts acceptances.
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [5:0]  mem_addr;
    logic [7:0]  mem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [5:0]  pc;
    logic        redirect;
    logic [5:0]  redirect_addr;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int accepted = 0;
    int exp_acc  = 0;

    typedef struct packed {
        logic [5:0]  pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] mem [64];

    fetch_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .mem_addr      (mem_addr),
        .mem_rdata     (mem_rdata),
        .instr         (instr),
        .instr_valid   (instr_valid),
        .instr_ready   (instr_ready),
        .pc            (pc),
        .redirect      (redirect),
        .redirect_addr (redirect_addr),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 8'(i);
    end

    always @(posedge clk) mem_rdata <= mem[mem_addr];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push_exp(input logic [5:0] p, input logic [31:0] w);
        exp_t e;
        e.pc    = p;
        e.instr = w;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_valid(input int max_cycles);
        int n;
        n = 0;
        while (!instr_valid && n < max_cycles) begin
            tick();
            n++;
        end
        check("wait_valid_timeout", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_valid"},    {31'd0, instr_valid}, 32'd0);
        check({tag, "_busy"},     {31'd0, busy},        32'd0);
        check({tag, "_pc"},       {26'd0, pc},          32'd0);
        check({tag, "_instr"},    instr,                32'd0);
        check({tag, "_mem_addr"}, {26'd0, mem_addr},    32'd0);
    endtask

    // Monitor: compare each newly presented word, verify hold while valid.
    logic        prev_valid = 1'b0;
    logic [31:0] prev_instr = '0;
    logic [5:0]  prev_pc    = '0;
    always @(negedge clk) begin
        if (instr_valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got pc=0x%02h instr=0x%08h expected none", pc, instr);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("word_pc",    {26'd0, pc}, {26'd0, e.pc});
                check("word_instr", instr,       e.instr);
            end
        end
        if (instr_valid && prev_valid) begin
            check("hold_instr", instr,       prev_instr);
            check("hold_pc",    {26'd0, pc}, {26'd0, prev_pc});
        end
        if (instr_valid && instr_ready) accepted++;
        prev_valid = instr_valid;
        prev_instr = instr;
        prev_pc    = pc;
    end

    initial begin
        rst = 1'b0; start = 1'b0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_addr = '0;
        repeat (3) tick();
        check_reset("reset");
        rst = 1'b1;
        tick();
        check("idle_busy", {31'd0, busy}, 32'd0);

        // Basic fetch and latency
        push_exp(6'h00, 32'h03020100);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("fetch_addr0", {26'd0, mem_addr}, 32'd0);
        check("fetch_busy", {31'd0, busy}, 32'd1);
        for (int b = 1; b < 4; b++) begin
            tick();
            check("fetch_addr", {26'd0, mem_addr}, 32'(b));
        end
        tick();
        check("latency_early", {31'd0, instr_valid}, 32'd0);
        tick();
        check("latency_5", {31'd0, instr_valid}, 32'd1);

        // Throughput: next word 6 cycles after the previous
        push_exp(6'h04, 32'h07060504);
        instr_ready = 1'b1; exp_acc++;
        tick();
        instr_ready = 1'b0;
        check("hs_drop", {31'd0, instr_valid}, 32'd0);
        repeat (4) tick();
        check("tput_early", {31'd0, instr_valid}, 32'd0);
        tick();
        check("tput_valid", {31'd0, instr_valid}, 32'd1);

        // Backpressure
        for (int i = 0; i < 10; i++) begin
            tick();
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_instr", instr, 32'h07060504);
            check("bp_pc", {26'd0, pc}, 32'h04);
            check("bp_mem_addr", {26'd0, mem_addr}, 32'h04);
        end
        push_exp(6'h08, 32'h0B0A0908);
        instr_ready = 1'b1; exp_acc++;
        tick();
        instr_ready = 1'b0;
        check("bp_single_accept", {31'd0, instr_valid}, 32'd0);
        wait_valid(10);

        // Redirect coincident with handshake
        check("coinc_pc", {26'd0, pc}, 32'h08);
        push_exp(6'h20, 32'h23222120);
        instr_ready = 1'b1; redirect = 1'b1; redirect_addr = 6'h20; exp_acc++;
        tick();
        instr_ready = 1'b0; redirect = 1'b0;
        check("coinc_mem_addr", {26'd0, mem_addr}, 32'h20);
        check("coinc_valid", {31'd0, instr_valid}, 32'd0);
        wait_valid(10);

        // Wrap
        push_exp(6'h3C, 32'h3F3E3D3C);
        redirect = 1'b1; redirect_addr = 6'h3C;
        tick();
        redirect = 1'b0;
        wait_valid(10);
        push_exp(6'h00, 32'h03020100);
        instr_ready = 1'b1; exp_acc++;
        tick();
        instr_ready = 1'b0;
        wait_valid(10);

        // Redirect at beat 2 of the fetch of pc 4
        instr_ready = 1'b1; exp_acc++;
        tick();
        instr_ready = 1'b0;
        repeat (2) tick();
        push_exp(6'h14, 32'h17161514);
        redirect = 1'b1; redirect_addr = 6'h17;
        tick();
        redirect = 1'b0;
        check("mid_mem_addr", {26'd0, mem_addr}, 32'h14);
        check("mid_valid", {31'd0, instr_valid}, 32'd0);
        repeat (4) tick();
        check("mid_early", {31'd0, instr_valid}, 32'd0);
        tick();
        check("mid_valid5", {31'd0, instr_valid}, 32'd1);

        // Reset during FETCH beat 3
        instr_ready = 1'b1; exp_acc++;
        tick();
        instr_ready = 1'b0;
        repeat (3) tick();
        check("beat3_mem_addr", {26'd0, mem_addr}, 32'h1B);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset("rst_fetch");
        repeat (3) tick();
        check("no_self_start", {31'd0, busy}, 32'd0);
        push_exp(6'h00, 32'h03020100);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10);

        // Reset during VALID
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset("rst_valid");
        push_exp(6'h00, 32'h03020100);
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(10);
        push_exp(6'h04, 32'h07060504);
        instr_ready = 1'b1; start = 1'b1; exp_acc++;
        tick();
        instr_ready = 1'b0; start = 1'b0;
        wait_valid(10);

        repeat (2) tick();
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("accept_count", 32'(accepted), 32'(exp_acc));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
